// File: rtl/morse_pulse_classifier.sv
// Measures keyed mark/space durations against dit/dah/word windows and emits DIT/DAH/LETTER_END/WORD_END/ERR.
// Optional input glitch filter: define MORSE_GLITCH_FILTER_EN.
`ifndef PULSE_CNT_W
`define PULSE_CNT_W 16
`endif

module morse_pulse_classifier #(
    parameter int CNT_W        = `PULSE_CNT_W,
    parameter int GLITCH_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             tick,
    input  logic             sig_in,
    input  logic             cfg_ready,
    input  logic [CNT_W-1:0] dit_time,
    input  logic [CNT_W-1:0] dah_time,
    input  logic [CNT_W-1:0] word_time,
    input  logic [CNT_W-1:0] tol_time,
    output logic             sym_valid,
    output logic [2:0]       sym_code,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;
    typedef enum logic [2:0] {
        SYM_DIT        = 3'd0,
        SYM_DAH        = 3'd1,
        SYM_LETTER_END = 3'd2,
        SYM_WORD_END   = 3'd3,
        SYM_ERR        = 3'd4
    } sym_t;

    function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        return (a >= b) ? a - b : '0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    logic sig_lvl;

`ifdef MORSE_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_TICKS + 1);
    logic          sig_filt;
    logic [GW-1:0] glitch_cnt;

    // Both edges wait the same number of ticks, so measured durations are preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_filt   <= 1'b0;
            glitch_cnt <= '0;
        end else if (ce) begin
            if (sig_in == sig_filt) begin
                glitch_cnt <= '0;
            end else if (tick) begin
                if (glitch_cnt == GW'(GLITCH_TICKS - 1)) begin
                    sig_filt   <= sig_in;
                    glitch_cnt <= '0;
                end else begin
                    glitch_cnt <= glitch_cnt + 1'b1;
                end
            end
        end
    end

    assign sig_lvl = sig_filt;
`else
    logic unused_glitch_ticks;
    assign unused_glitch_ticks = (GLITCH_TICKS != 0);
    assign sig_lvl = sig_in;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0] sh_dit, sh_dah, sh_word, sh_tol;
    logic             letter_pending, lp_nxt;
    logic             emit;
    sym_t             emit_code;

    logic [CNT_W-1:0] dit_lo, dit_hi, dah_lo, dah_hi, word_thr;

    assign dit_lo   = sat_sub(sh_dit, sh_tol);
    assign dit_hi   = sat_add(sh_dit, sh_tol);
    assign dah_lo   = sat_sub(sh_dah, sh_tol);
    assign dah_hi   = sat_add(sh_dah, sh_tol);
    assign word_thr = sat_sub(sh_word, sh_tol);
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
    assign busy     = (state != IDLE);

    // NOTE: every output of this block is given a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lp_nxt    = letter_pending;
        emit      = 1'b0;
        emit_code = SYM_DIT;
        unique case (state)
            IDLE: begin
                if (cfg_ready && sig_lvl) begin
                    state_nxt = MARK;
                    cnt_nxt   = '0;
                end
            end
            MARK: begin
                if (!sig_lvl) begin
                    emit      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SPACE;
                    if (cnt >= dit_lo && cnt <= dit_hi) begin
                        emit_code = SYM_DIT;
                        lp_nxt    = 1'b1;
                    end else if (cnt >= dah_lo && cnt <= dah_hi) begin
                        emit_code = SYM_DAH;
                        lp_nxt    = 1'b1;
                    end else begin
                        emit_code = SYM_ERR;
                    end
                end else if (tick) begin
                    cnt_nxt = cnt_inc;
                end
            end
            SPACE: begin
                if (sig_lvl) begin
                    state_nxt = MARK;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    cnt_nxt = cnt_inc;
                    // Word gap takes precedence when both thresholds land on the same tick.
                    if (cnt_inc >= word_thr) begin
                        emit      = 1'b1;
                        emit_code = SYM_WORD_END;
                        lp_nxt    = 1'b0;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (letter_pending && cnt_inc >= dah_lo) begin
                        emit      = 1'b1;
                        emit_code = SYM_LETTER_END;
                        lp_nxt    = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            letter_pending <= 1'b0;
            sym_valid      <= 1'b0;
            sym_code       <= 3'd0;
            sh_dit         <= '0;
            sh_dah         <= '0;
            sh_word        <= '0;
            sh_tol         <= '0;
        end else if (ce) begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            letter_pending <= lp_nxt;
            sym_valid      <= emit;
            if (emit) sym_code <= emit_code;
            if (state == IDLE && cfg_ready) begin
                sh_dit  <= dit_time;
                sh_dah  <= dah_time;
                sh_word <= word_time;
                sh_tol  <= tol_time;
            end
        end
    end

endmodule
